// File: rtl/blackbox_seq.sv
// Nibble-serial sequencer for the dual-rail blackbox lane: spacer, settle, capture, reassemble.
// Operands are latched on accept; results are presented with a valid/ready handshake.
module blackbox_seq #(
  parameter int unsigned BIT_SIZE      = 4,
  parameter int unsigned WORD_W        = 32,
  parameter int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned N            = WORD_W / BIT_SIZE,
  localparam int unsigned NIB_W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_x,
  input  logic [WORD_W-1:0]   in_k,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_s,
  output logic [BIT_SIZE-1:0] x_top,
  output logic [BIT_SIZE-1:0] x_bar_top,
  output logic [BIT_SIZE-1:0] k_top,
  output logic [BIT_SIZE-1:0] k_bar_top,
  input  logic [BIT_SIZE-1:0] s_top,
  output logic                busy,
  output logic [NIB_W-1:0]    nib_idx
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [NIB_W-1:0] NibLast = NIB_W'(N - 1);

  if (WORD_W % BIT_SIZE != 0) begin : g_bad_word
    $error("WORD_W must be a multiple of BIT_SIZE");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StSpacer, StEval, StDone} state_e;

  state_e              state_q;
  logic [WORD_W-1:0]   x_q;
  logic [WORD_W-1:0]   k_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BIT_SIZE-1:0] x_nib;
  logic [BIT_SIZE-1:0] k_nib;

  assign x_nib = x_q[nib_idx*BIT_SIZE +: BIT_SIZE];
  assign k_nib = k_q[nib_idx*BIT_SIZE +: BIT_SIZE];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      x_q       <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_s     <= '0;
      busy      <= 1'b0;
      nib_idx   <= '0;
      x_top     <= '0;
      x_bar_top <= '0;
      k_top     <= '0;
      k_bar_top <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q      <= in_x;
            k_q      <= in_k;
            out_s    <= '0;
            nib_idx  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= StSpacer;
          end
        end
        StSpacer: begin
          // Rails go live on this edge so the first EVAL cycle already carries data.
          cnt_q     <= '0;
          x_top     <= x_nib;
          x_bar_top <= ~x_nib;
          k_top     <= k_nib;
          k_bar_top <= ~k_nib;
          state_q   <= StEval;
        end
        StEval: begin
          if (cnt_q == CntLast) begin
            out_s[nib_idx*BIT_SIZE +: BIT_SIZE] <= s_top;
            x_top     <= '0;
            x_bar_top <= '0;
            k_top     <= '0;
            k_bar_top <= '0;
            if (nib_idx == NibLast) begin
              nib_idx   <= '0;
              out_valid <= 1'b1;
              state_q   <= StDone;
            end else begin
              nib_idx <= nib_idx + 1'b1;
              state_q <= StSpacer;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
